// File: rtl/fifo_param.sv
// Parameterised synchronous show-ahead FIFO: all DEPTH words usable, flags decoded
// from the registered level, and sticky overflow/underflow cleared only by flush or reset.
module fifo_param #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr,
   input  logic              i_rd,
   input  logic              i_flush,
   input  logic [DATA_W-1:0] i_data_in,
   output logic [DATA_W-1:0] o_data_out,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_almost_full,
   output logic              o_almost_empty,
   output logic [AW:0]       o_level,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam logic [AW:0]   LV_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LV_AF   = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0]   LV_AE   = (AW+1)'(AE_LEVEL);
   localparam logic [AW:0]   LV_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_level;
   logic              r_overflow;
   logic              r_underflow;

   logic [AW-1:0]     w_wr_ptr_next;
   logic [AW-1:0]     w_rd_ptr_next;
   logic [AW:0]       w_level_next;
   logic              w_overflow_next;
   logic              w_underflow_next;
   logic              w_wa;
   logic              w_ra;

   // Acceptance looks only at the registered flags, so wr/rd never reach the flags combinationally.
   assign w_wa = i_wr & ~o_full;
   assign w_ra = i_rd & ~o_empty;

   always_comb begin
      w_wr_ptr_next    = r_wr_ptr;
      w_rd_ptr_next    = r_rd_ptr;
      w_level_next     = r_level;
      w_overflow_next  = r_overflow;
      w_underflow_next = r_underflow;
      if (i_flush) begin
         w_wr_ptr_next    = '0;
         w_rd_ptr_next    = '0;
         w_level_next     = '0;
         w_overflow_next  = 1'b0;
         w_underflow_next = 1'b0;
      end else begin
         if (w_wa)
            w_wr_ptr_next = r_wr_ptr + PTR_ONE;
         if (w_ra)
            w_rd_ptr_next = r_rd_ptr + PTR_ONE;
         case ({w_wa, w_ra})
            2'b10:   w_level_next = r_level + LV_ONE;
            2'b01:   w_level_next = r_level - LV_ONE;
            default: w_level_next = r_level;
         endcase
         if (i_wr && o_full)
            w_overflow_next = 1'b1;
         if (i_rd && o_empty)
            w_underflow_next = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wr_ptr    <= w_wr_ptr_next;
         r_rd_ptr    <= w_rd_ptr_next;
         r_level     <= w_level_next;
         r_overflow  <= w_overflow_next;
         r_underflow <= w_underflow_next;
      end
   end

   // Storage is deliberately left out of reset and flush so it maps onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (w_wa && !i_flush)
         r_mem[r_wr_ptr] <= i_data_in;
   end

   assign o_data_out     = r_mem[r_rd_ptr];
   assign o_level        = r_level;
   assign o_full         = (r_level == LV_FULL);
   assign o_empty        = (r_level == '0);
   assign o_almost_full  = (r_level >= LV_AF);
   assign o_almost_empty = (r_level <= LV_AE);
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: default 8x16 instance plus a 32x4 instance.
module tb_fifo_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr, rd, flush;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        full, empty, afull, aempty, ovf, udf;
   logic [4:0]  level;

   logic        s_wr, s_rd, s_flush;
   logic [31:0] s_din, s_dout;
   logic        s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
   logic [2:0]  s_level;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_param u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_rd(rd), .i_flush(flush),
      .i_data_in(din), .o_data_out(dout), .o_full(full), .o_empty(empty),
      .o_almost_full(afull), .o_almost_empty(aempty), .o_level(level),
      .o_overflow(ovf), .o_underflow(udf)
   );

   fifo_param #(.DATA_W(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_small (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr(s_wr), .i_rd(s_rd), .i_flush(s_flush),
      .i_data_in(s_din), .o_data_out(s_dout), .o_full(s_full), .o_empty(s_empty),
      .o_almost_full(s_afull), .o_almost_empty(s_aempty), .o_level(s_level),
      .o_overflow(s_ovf), .o_underflow(s_udf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic fill_seq(input int n);
      for (int i = 1; i <= n; i++) begin
         wr = 1'b1; din = 8'(i);
         tick();
      end
      wr = 1'b0;
   endtask

   task automatic test_reset();
      n_vec++;
      if ({empty, aempty, full, afull, ovf, udf} !== 6'b110000 || level !== 5'd0) begin
         n_err++;
         $display("FAIL reset_flags: got e/ae/f/af/ov/un=%b level=%0d, want 110000 level=0",
                  {empty, aempty, full, afull, ovf, udf}, level);
      end
      n_vec++;
      if (s_empty !== 1'b1 || s_level !== 3'd0) begin
         n_err++;
         $display("FAIL reset_small: got empty=%b level=%0d, want 1 0", s_empty, s_level);
      end
      #3 rst_n = 1'b1;
      tick();
      $display("reset released, level=%0d empty=%b", level, empty);
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 16; i++) begin
         wr = 1'b1; din = 8'(i);
         tick();
         n_vec++;
         if (level !== 5'(i) || full !== (i == 16) || afull !== (i >= 14) || aempty !== (i <= 2)) begin
            n_err++;
            $display("FAIL fill_%0d: got level=%0d f=%b af=%b ae=%b, want level=%0d f=%b af=%b ae=%b",
                     i, level, full, afull, aempty, i, i == 16, i >= 14, i <= 2);
         end
         $display("write 0x%02h level=%0d", din, level);
      end
      wr = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         n_vec++;
         if (dout !== 8'(i)) begin
            n_err++;
            $display("FAIL drain_data_%0d: got 0x%02h, want 0x%02h", i, dout, 8'(i));
         end
         $display("read 0x%02h", dout);
         rd = 1'b1;
         tick();
      end
      rd = 1'b0;
      n_vec++;
      if (empty !== 1'b1 || level !== 5'd0 || udf !== 1'b0) begin
         n_err++;
         $display("FAIL drain_empty: got empty=%b level=%0d un=%b, want 1 0 0", empty, level, udf);
      end
   endtask

   task automatic test_full_wr_rd();
      fill_seq(16);
      wr = 1'b1; rd = 1'b1; din = 8'hAA;
      tick();
      wr = 1'b0; rd = 1'b0;
      $display("full wr+rd: level=%0d ovf=%b dout=0x%02h", level, ovf, dout);
      n_vec++;
      if (level !== 5'd15 || ovf !== 1'b1 || dout !== 8'h02 || udf !== 1'b0) begin
         n_err++;
         $display("FAIL full_wr_rd: got level=%0d ovf=%b dout=0x%02h un=%b, want 15 1 0x02 0",
                  level, ovf, dout, udf);
      end
      for (int i = 2; i <= 16; i++) begin
         n_vec++;
         if (dout !== 8'(i)) begin
            n_err++;
            $display("FAIL full_drain_%0d: got 0x%02h, want 0x%02h", i, dout, 8'(i));
         end
         rd = 1'b1;
         tick();
      end
      rd = 1'b0;
      n_vec++;
      if (empty !== 1'b1 || ovf !== 1'b1) begin
         n_err++;
         $display("FAIL full_sticky: got empty=%b ovf=%b, want 1 1", empty, ovf);
      end
      do_flush();
      n_vec++;
      if (ovf !== 1'b0) begin
         n_err++;
         $display("FAIL full_flush_ovf: got %b, want 0", ovf);
      end
   endtask

   task automatic test_empty_wr_rd();
      wr = 1'b1; rd = 1'b1; din = 8'h5C;
      tick();
      wr = 1'b0; rd = 1'b0;
      $display("empty wr+rd: level=%0d udf=%b dout=0x%02h", level, udf, dout);
      n_vec++;
      if (level !== 5'd1 || udf !== 1'b1 || empty !== 1'b0 || dout !== 8'h5C || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL empty_wr_rd: got level=%0d un=%b e=%b dout=0x%02h ov=%b, want 1 1 0 0x5C 0",
                  level, udf, empty, dout, ovf);
      end
      do_flush();
      n_vec++;
      if (udf !== 1'b0 || level !== 5'd0) begin
         n_err++;
         $display("FAIL empty_flush: got un=%b level=%0d, want 0 0", udf, level);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         wr = 1'b1; din = 8'(i);
         tick();
      end
      for (int c = 0; c < 40; c++) begin
         n_vec++;
         if (dout !== 8'(c)) begin
            n_err++;
            $display("FAIL stream_data_%0d: got 0x%02h, want 0x%02h", c, dout, 8'(c));
         end
         wr = 1'b1; rd = 1'b1; din = 8'(c + 8);
         tick();
         n_vec++;
         if (level !== 5'd8) begin
            n_err++;
            $display("FAIL stream_level_%0d: got %0d, want 8", c, level);
         end
      end
      wr = 1'b0;
      $display("stream done, level=%0d", level);
      for (int c = 40; c < 48; c++) begin
         n_vec++;
         if (dout !== 8'(c)) begin
            n_err++;
            $display("FAIL stream_tail_%0d: got 0x%02h, want 0x%02h", c, dout, 8'(c));
         end
         tick();
      end
      rd = 1'b0;
      n_vec++;
      if (empty !== 1'b1) begin
         n_err++;
         $display("FAIL stream_empty: got %b, want 1", empty);
      end
   endtask

   // Builds level 5 with the sticky overflow flag set.
   task automatic make_level5_ovf();
      fill_seq(16);
      wr = 1'b1; din = 8'hEE;
      tick();
      wr = 1'b0;
      for (int i = 0; i < 11; i++) begin
         rd = 1'b1;
         tick();
      end
      rd = 1'b0;
   endtask

   task automatic test_flush();
      make_level5_ovf();
      n_vec++;
      if (level !== 5'd5 || ovf !== 1'b1 || dout !== 8'd12) begin
         n_err++;
         $display("FAIL flush_setup: got level=%0d ovf=%b dout=0x%02h, want 5 1 0x0c", level, ovf, dout);
      end
      flush = 1'b1; wr = 1'b1; din = 8'h99;
      tick();
      flush = 1'b0; wr = 1'b0;
      $display("flush: level=%0d empty=%b ovf=%b", level, empty, ovf);
      n_vec++;
      if (level !== 5'd0 || empty !== 1'b1 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL flush_clear: got level=%0d empty=%b ovf=%b, want 0 1 0", level, empty, ovf);
      end
   endtask

   task automatic test_async_reset();
      make_level5_ovf();
      #3 rst_n = 1'b0;
      #1;
      $display("async reset: level=%0d empty=%b ovf=%b", level, empty, ovf);
      n_vec++;
      if (level !== 5'd0 || empty !== 1'b1 || ovf !== 1'b0 || aempty !== 1'b1) begin
         n_err++;
         $display("FAIL async_reset: got level=%0d empty=%b ovf=%b ae=%b, want 0 1 0 1",
                  level, empty, ovf, aempty);
      end
      #1 rst_n = 1'b1;
      tick();
      wr = 1'b1; din = 8'h77;
      tick();
      wr = 1'b0;
      n_vec++;
      if (dout !== 8'h77 || level !== 5'd1) begin
         n_err++;
         $display("FAIL reset_first_word: got dout=0x%02h level=%0d, want 0x77 1", dout, level);
      end
      do_flush();
   endtask

   task automatic test_small();
      logic [31:0] words [4];
      words[0] = 32'hDEADBEEF; words[1] = 32'h12345678;
      words[2] = 32'hCAFEF00D; words[3] = 32'h0BADC0DE;
      for (int k = 1; k <= 4; k++) begin
         s_wr = 1'b1; s_din = words[k-1];
         tick();
         $display("small write 0x%08h level=%0d", s_din, s_level);
         n_vec++;
         if (s_level !== 3'(k) || s_afull !== (k >= 3) || s_full !== (k == 4) || s_aempty !== (k <= 1)) begin
            n_err++;
            $display("FAIL small_fill_%0d: got level=%0d af=%b f=%b ae=%b, want %0d %b %b %b",
                     k, s_level, s_afull, s_full, s_aempty, k, k >= 3, k == 4, k <= 1);
         end
      end
      s_wr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (s_dout !== words[k]) begin
            n_err++;
            $display("FAIL small_read_%0d: got 0x%08h, want 0x%08h", k, s_dout, words[k]);
         end
         s_rd = 1'b1;
         tick();
      end
      s_rd = 1'b0;
      n_vec++;
      if (s_empty !== 1'b1 || s_udf !== 1'b0) begin
         n_err++;
         $display("FAIL small_empty: got empty=%b un=%b, want 1 0", s_empty, s_udf);
      end
   endtask

   initial begin
      rst_n = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0; din = '0;
      s_wr = 1'b0; s_rd = 1'b0; s_flush = 1'b0; s_din = '0;
      tick();
      tick();
      test_reset();
      test_fill_drain();
      test_full_wr_rd();
      test_empty_wr_rd();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_small();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
